chan_512_bin_loader: RTL and testbench

Converts the software-written load-bins control word into single-cycle write transactions on the channel-select table of the 512-channel channelizer. It sits directly downstream of the PPC-to-fabric load-bins register, in the `user_clk` domain. It filters and edge-detects the register word and issues one table write per software strobe. It also provides a table-wide clear sweep and reports busy, write-count and overrun status back to software-visible registers.

---
 rtl/chan_512_bin_loader_if.sv | 12 +
 rtl/chan_512_bin_loader.sv | 150 +++++++++++++++
 tb/tb_chan_512_bin_loader.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/chan_512_bin_loader_if.sv
// Channel-select table write port: one entry written per cycle while tbl_we is high.
interface chan_512_bin_loader_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 16
);
  logic              tbl_we;
  logic [ADDR_W-1:0] tbl_addr;
  logic [DATA_W-1:0] tbl_data;

  modport master (output tbl_we, tbl_addr, tbl_data);
  modport slave  (input  tbl_we, tbl_addr, tbl_data);
endinterface

// File: rtl/chan_512_bin_loader.sv
// Turns software load-bins strobes into channel-select table writes or a full clear sweep.
// Latency 3 edges from register change to first write; no backpressure, one pending write, excess strobes set ovr.
module chan_512_bin_loader #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 16
) (
  input  logic                         user_clk,
  input  logic                         user_rst,
  input  logic [31:0]                  user_data_out,
  chan_512_bin_loader_if.master        tbl,
  output logic                         busy,
  output logic [15:0]                  load_count,
  output logic                         ovr
);

  localparam logic [31:0] FIELD_MASK = 32'hC000_0000
                                     | (((32'd1 << ADDR_W) - 32'd1) << 16)
                                     | ((32'd1 << DATA_W) - 32'd1);

  typedef enum logic [1:0] {IDLE, WRITE, CLEAR} state_t;

  state_t            state, state_nxt;
  logic [31:0]       q1, q2;
  logic              q1_vld, q2_vld, armed, h31, h30;
  logic              stable, wr_req, clr_req, take_pend, wr_direct, store;
  logic [ADDR_W-1:0] req_addr, pend_addr, addr_r, addr_nxt;
  logic [DATA_W-1:0] req_data, pend_data, data_r, data_nxt;
  logic              pend_vld;

  // Ignored bits are masked so their skew cannot hold off a real command.
  assign stable   = q2_vld && (((q1 ^ q2) & FIELD_MASK) == 32'd0);
  assign wr_req   = armed && stable && q2[31] && !h31;
  assign clr_req  = armed && stable && q2[30] && !h30;
  assign req_addr = q2[16 +: ADDR_W];
  assign req_data = q2[DATA_W-1:0];
  assign store    = wr_req && !wr_direct;

  always_ff @(posedge user_clk or posedge user_rst) begin
    if (user_rst) begin
      q1     <= '0;
      q2     <= '0;
      q1_vld <= 1'b0;
      q2_vld <= 1'b0;
      armed  <= 1'b0;
      h31    <= 1'b0;
      h30    <= 1'b0;
    end else begin
      q1     <= user_data_out;
      q2     <= q1;
      q1_vld <= 1'b1;
      q2_vld <= q1_vld;
      if (stable) begin
        armed <= 1'b1;
        h31   <= q2[31];
        h30   <= q2[30];
      end
    end
  end

  // During CLEAR the address register doubles as the sweep counter.
  always_comb begin
    state_nxt = state;
    addr_nxt  = addr_r;
    data_nxt  = data_r;
    take_pend = 1'b0;
    wr_direct = 1'b0;
    case (state)
      IDLE: begin
        if (clr_req) begin
          state_nxt = CLEAR;
          addr_nxt  = '0;
          data_nxt  = '0;
        end else if (pend_vld) begin
          state_nxt = WRITE;
          take_pend = 1'b1;
          addr_nxt  = pend_addr;
          data_nxt  = pend_data;
        end else if (wr_req) begin
          state_nxt = WRITE;
          wr_direct = 1'b1;
          addr_nxt  = req_addr;
          data_nxt  = req_data;
        end
      end
      WRITE: begin
        if (clr_req) begin
          state_nxt = CLEAR;
          addr_nxt  = '0;
          data_nxt  = '0;
        end else begin
          state_nxt = IDLE;
        end
      end
      CLEAR: begin
        data_nxt = '0;
        if (clr_req) begin
          addr_nxt = '0;
        end else if (&addr_r) begin
          if (pend_vld) begin
            state_nxt = WRITE;
            take_pend = 1'b1;
            addr_nxt  = pend_addr;
            data_nxt  = pend_data;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          addr_nxt = addr_r + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge user_clk or posedge user_rst) begin
    if (user_rst) begin
      state      <= IDLE;
      addr_r     <= '0;
      data_r     <= '0;
      load_count <= '0;
      pend_vld   <= 1'b0;
      pend_addr  <= '0;
      pend_data  <= '0;
      ovr        <= 1'b0;
    end else begin
      state  <= state_nxt;
      addr_r <= addr_nxt;
      data_r <= data_nxt;
      if (state_nxt == WRITE) load_count <= load_count + 16'd1;
      // A slot being drained this cycle can take the new request without loss.
      if (store) begin
        if (pend_vld && !take_pend) begin
          ovr <= 1'b1;
        end else begin
          pend_vld  <= 1'b1;
          pend_addr <= req_addr;
          pend_data <= req_data;
        end
      end else if (take_pend) begin
        pend_vld <= 1'b0;
      end
    end
  end

  assign tbl.tbl_we   = (state != IDLE);
  assign tbl.tbl_addr = addr_r;
  assign tbl.tbl_data = data_r;
  assign busy         = (state != IDLE) || pend_vld;

endmodule

// File: tb/tb_chan_512_bin_loader.sv
// Bench for chan_512_bin_loader: directed scenarios plus a randomized run against a table model.
module tb_chan_512_bin_loader;
  localparam int AW = 9;
  localparam int DW = 16;
  localparam int N  = 512;

  typedef struct {
    int            c;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic          b;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] din;
  logic        busy;
  logic [15:0] load_count;
  logic        ovr;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int exp_count = 0;

  wr_t         log_q[$];
  logic [DW-1:0] mirror [0:N-1];
  logic [DW-1:0] model  [0:N-1];

  chan_512_bin_loader_if #(.ADDR_W(AW), .DATA_W(DW)) tbl();

  chan_512_bin_loader #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .user_clk      (clk),
    .user_rst      (rst),
    .user_data_out (din),
    .tbl           (tbl),
    .busy          (busy),
    .load_count    (load_count),
    .ovr           (ovr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (tbl.tbl_we === 1'b1) begin
      log_q.push_back('{cyc, tbl.tbl_addr, tbl.tbl_data, busy});
      mirror[tbl.tbl_addr] = tbl.tbl_data;
    end
  end

  task automatic drive(input logic [31:0] w);
    @(posedge clk);
    #1;
    din = w;
  endtask

  task automatic hold(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic wait_cyc(input int t);
    @(negedge clk);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy !== 1'b0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 3000) begin
      errors++;
      $display("FAIL wait_idle: busy=%b after %0d cycles, required 0", busy, n);
    end
  endtask

  // Number of entries in a clear sweep that deviate from addr i, data 0, cycle k+3+i, busy high.
  function automatic int clear_bad(input int start, input int k);
    int bad = 0;
    for (int i = 0; i < N; i++) begin
      if (start + i >= log_q.size()) bad++;
      else if (log_q[start+i].c != k + 3 + i || log_q[start+i].a != AW'(i) ||
               log_q[start+i].d !== '0 || log_q[start+i].b !== 1'b1) bad++;
    end
    return bad;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    din = 32'h8000_0000;
    hold(3);
    @(negedge clk);
    checks++; if (tbl.tbl_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b want 0", tbl.tbl_we); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (load_count !== 16'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", load_count); end
    checks++; if (ovr !== 1'b0) begin errors++; $display("FAIL reset_ovr: got %b want 0", ovr); end
    checks++; if (tbl.tbl_addr !== '0 || tbl.tbl_data !== '0) begin errors++; $display("FAIL reset_bus: got %h/%h want 0/0", tbl.tbl_addr, tbl.tbl_data); end
    rst = 1'b0;
    hold(10);
    @(negedge clk);
    checks++; if (log_q.size() != 0) begin errors++; $display("FAIL arming_no_write: got %0d writes want 0", log_q.size()); end
    checks++; if (load_count !== 16'd0) begin errors++; $display("FAIL arming_count: got %0d want 0", load_count); end
    drive(32'h0);
    hold(4);
  endtask

  task automatic test_single_write();
    int k;
    log_q.delete();
    drive(32'h8012_0ABC);
    k = cyc;
    hold(4);
    drive(32'h0);
    hold(5);
    @(negedge clk);
    exp_count++;
    checks++; if (log_q.size() != 1) begin errors++; $display("FAIL single_pulses: got %0d want 1", log_q.size()); end
    if (log_q.size() >= 1) begin
      checks++; if (log_q[0].c != k + 3) begin errors++; $display("FAIL single_latency: got cycle %0d want %0d", log_q[0].c, k + 3); end
      checks++; if (log_q[0].a !== 9'h012 || log_q[0].d !== 16'h0ABC) begin errors++; $display("FAIL single_payload: got %h/%h want 012/0abc", log_q[0].a, log_q[0].d); end
    end
    checks++; if (load_count !== 16'(exp_count)) begin errors++; $display("FAIL single_count: got %0d want %0d", load_count, exp_count); end
    checks++; if (tbl.tbl_addr !== 9'h012 || tbl.tbl_data !== 16'h0ABC) begin errors++; $display("FAIL single_hold: got %h/%h want 012/0abc", tbl.tbl_addr, tbl.tbl_data); end
  endtask

  task automatic test_clear();
    int k;
    log_q.delete();
    drive(32'h4000_0000);
    k = cyc;
    hold(3);
    drive(32'h0);
    wait_cyc(k + 3 + N);
    checks++; if (busy !== 1'b0 || tbl.tbl_we !== 1'b0) begin errors++; $display("FAIL clear_end: got busy=%b we=%b want 0/0", busy, tbl.tbl_we); end
    checks++; if (log_q.size() != N) begin errors++; $display("FAIL clear_len: got %0d want %0d", log_q.size(), N); end
    checks++; if (clear_bad(0, k) != 0) begin errors++; $display("FAIL clear_sweep: got %0d bad entries want 0", clear_bad(0, k)); end
    checks++; if (load_count !== 16'(exp_count)) begin errors++; $display("FAIL clear_count: got %0d want %0d", load_count, exp_count); end
  endtask

  task automatic test_simultaneous();
    int k;
    log_q.delete();
    drive(32'hC1FF_1234);
    k = cyc;
    hold(3);
    drive(32'h0);
    wait_cyc(k + 3 + N + 3);
    exp_count++;
    checks++; if (log_q.size() != N + 1) begin errors++; $display("FAIL simul_len: got %0d want %0d", log_q.size(), N + 1); end
    checks++; if (clear_bad(0, k) != 0) begin errors++; $display("FAIL simul_sweep: got %0d bad entries want 0", clear_bad(0, k)); end
    if (log_q.size() > N) begin
      checks++;
      if (log_q[N].c != k + 3 + N || log_q[N].a !== 9'h1FF || log_q[N].d !== 16'h1234) begin
        errors++; $display("FAIL simul_write: got c=%0d %h/%h want c=%0d 1ff/1234", log_q[N].c, log_q[N].a, log_q[N].d, k + 3 + N);
      end
    end
    checks++; if (load_count !== 16'(exp_count) || ovr !== 1'b0) begin errors++; $display("FAIL simul_status: got count=%0d ovr=%b want %0d/0", load_count, ovr, exp_count); end
  endtask

  task automatic test_overrun();
    int k;
    log_q.delete();
    drive(32'h4000_0000);
    k = cyc;
    hold(3); drive(32'h0);
    hold(3); drive(32'h8005_0005);
    hold(3); drive(32'h0);
    hold(3); drive(32'h8006_0006);
    hold(3); drive(32'h0);
    wait_cyc(k + 3 + N + 5);
    exp_count++;
    checks++; if (log_q.size() != N + 1) begin errors++; $display("FAIL ovr_len: got %0d want %0d", log_q.size(), N + 1); end
    if (log_q.size() > N) begin
      checks++;
      if (log_q[N].c != k + 3 + N || log_q[N].a !== 9'h005 || log_q[N].d !== 16'h0005) begin
        errors++; $display("FAIL ovr_write: got c=%0d %h/%h want c=%0d 005/0005", log_q[N].c, log_q[N].a, log_q[N].d, k + 3 + N);
      end
    end
    checks++; if (ovr !== 1'b1) begin errors++; $display("FAIL ovr_flag: got %b want 1", ovr); end
    checks++; if (load_count !== 16'(exp_count)) begin errors++; $display("FAIL ovr_count: got %0d want %0d", load_count, exp_count); end
  endtask

  task automatic test_random();
    int exp_we = 0;
    int bad = 0;
    log_q.delete();
    for (int op = 0; op < 40; op++) begin
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      logic [4:0]    junk;
      a    = AW'($urandom_range(0, N - 1));
      d    = DW'($urandom);
      junk = 5'($urandom);
      wait_idle();
      if (op == 0 || $urandom_range(0, 9) == 0) begin
        drive({2'b01, junk, 25'($urandom)});
        for (int i = 0; i < N; i++) model[i] = '0;
        exp_we += N;
      end else begin
        drive({2'b10, junk, a, d});
        model[a] = d;
        exp_we++;
        exp_count++;
      end
      hold(3);
      drive({2'b00, 30'($urandom)});
      hold(3);
    end
    wait_idle();
    hold(2);
    @(negedge clk);
    for (int i = 0; i < N; i++) if (mirror[i] !== model[i]) bad++;
    checks++; if (log_q.size() != exp_we) begin errors++; $display("FAIL rand_we_cycles: got %0d want %0d", log_q.size(), exp_we); end
    checks++; if (bad != 0) begin errors++; $display("FAIL rand_table: got %0d mismatched entries want 0", bad); end
    checks++; if (load_count !== 16'(exp_count)) begin errors++; $display("FAIL rand_count: got %0d want %0d", load_count, exp_count); end
    checks++; if (ovr !== 1'b1) begin errors++; $display("FAIL rand_ovr_sticky: got %b want 1", ovr); end
  endtask

  task automatic test_reset_mid_sweep();
    int n = 0;
    int sz;
    drive(32'h4000_0000);
    hold(3);
    drive(32'h0);
    @(negedge clk);
    while (!(tbl.tbl_we === 1'b1 && tbl.tbl_addr === 9'd200) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    checks++; if (n >= 1000) begin errors++; $display("FAIL mid_reach200: got addr %0d after %0d cycles want 200", tbl.tbl_addr, n); end
    rst = 1'b1;
    #1;
    checks++; if (tbl.tbl_we !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL mid_async: got we=%b busy=%b want 0/0", tbl.tbl_we, busy); end
    checks++; if (load_count !== 16'd0 || ovr !== 1'b0) begin errors++; $display("FAIL mid_status: got count=%0d ovr=%b want 0/0", load_count, ovr); end
    sz = log_q.size();
    hold(3);
    @(negedge clk);
    rst = 1'b0;
    hold(600);
    @(negedge clk);
    checks++; if (log_q.size() != sz) begin errors++; $display("FAIL mid_no_resume: got %0d new writes want 0", log_q.size() - sz); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy_after: got %b want 0", busy); end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_clear();
    test_simultaneous();
    test_overrun();
    test_random();
    test_reset_mid_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
